dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-port arbiter sharing one single-port synchronous RAM between the instruction-fetch read port and the EXE/MEM data port of the 5-stage pipeline. It sits between the pipeline stages and the unified RAM and grants at most one access per cycle using round-robin priority. It routes each 1-cycle-latency read response back to its owner. A one-entry hold slot per port absorbs response back-pressure when a downstream stage stalls.

## Interface
- No parameters; address/data 32 bits, byte-enable 4 bits.
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch read request
- inst_addr  in  32  fetch byte address
- inst_gnt  out  1  request accepted this cycle (combinational)
- inst_rvalid  out  1  fetch read data valid
- inst_rdata  out  32  fetch read data
- inst_rready  in  1  fetch consumer accepts data
- data_req  in  1  data request, read or write
- data_we  in  4  byte write enables; 4'b0000 = read
- data_addr  in  32  data byte address
- data_wdata  in  32  store data, already byte-lane aligned
- data_gnt  out  1  request accepted this cycle (combinational)
- data_rvalid  out  1  load data valid
- data_rdata  out  32  load data
- data_rready  in  1  load consumer accepts data
- ram_en  out  1  RAM enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after a read with ram_en=1

## Operation
- Each port has a response slot with three states:
  - EMPTY: no read outstanding.
  - INFLIGHT: read issued last cycle; data is on ram_rdata.
  - HELD: data captured in the hold register.
- Port rvalid = slot is INFLIGHT or HELD.
- Port rdata = ram_rdata when INFLIGHT, hold register when HELD, 0 when EMPTY.
- Slot "frees" this cycle when rvalid & rready.
- Eligibility:
  - inst is eligible when inst_req & (slot EMPTY or slot frees this cycle).
  - A data read (data_we==0) follows the same rule as inst.
  - A data write (data_we!=0) is eligible whenever data_req; it never touches the slot.
- Arbitration:
  - If only one port is eligible, it is granted.
  - If both are eligible, the port not recorded in the round-robin pointer `last` is granted.
  - `last` updates to the granted port on every grant; it holds when there is no grant.
- RAM drive:
  - ram_en = inst_gnt | data_gnt.
  - ram_addr and ram_wdata are taken from the granted port.
  - ram_we = data_gnt ? data_we : 0.
  - When idle, ram_addr, ram_wdata and ram_we are 0.
- Slot transitions, in priority order:
  1. Read granted: next state INFLIGHT. Legal only from EMPTY or a freeing slot.
  2. INFLIGHT & ~rready: capture ram_rdata into the hold register; next state HELD.
  3. Slot frees: next state EMPTY.
  4. Otherwise: hold state.
- gnt is never asserted without req.
- Ungranted requesters must hold req/addr/we/wdata stable until granted.

## Timing
- Grant is combinational in the request cycle. The write commits at that clock edge.
- Read data is presented with rvalid exactly 1 cycle after grant when the slot was EMPTY or freeing. It stays valid, stable, until rready.
- With rready held high, each port sustains one read per cycle if uncontested. Contested: the ports alternate, 1 grant per cycle total.
- A HELD port is blocked from new reads until its data is consumed. On the consuming cycle a new read may be granted (back-to-back).
- Reset (resetn=0, async):
  - Both slots go EMPTY; `last` = inst, so data wins the first conflict.
  - All rvalid go to 0 immediately; hold registers are cleared to 0.
  - A read issued in the cycle before reset produces no rvalid after release.
- Outputs during reset: rvalid=0, rdata=0. gnt and ram_* follow req combinationally. Pipeline valids are low in reset, so no RAM access occurs.

## Test plan
- Single fetch: inst_req=1, inst_addr=0x1C000000, RAM word 0x02800413, inst_rready=1 -> inst_gnt same cycle; next cycle inst_rvalid=1, inst_rdata=0x02800413; ram_we=0.
- Conflict round-robin: both ports request reads every cycle from reset, both rready=1 -> grants in order data, inst, data, inst; ram_en=1 every cycle; each response goes to the correct port.
- Byte store: data_we=4'b0100, data_addr=0x104, data_wdata=0x00AB0000 -> ram_we=4'b0100 in grant cycle, data_rvalid stays 0. Subsequent read of 0x104 returns only byte 2 updated.
- Back-pressure: data read of 0x200 (value 0xDEADBEEF) with data_rready=0 for 3 cycles:
  - Slot goes HELD; data_rvalid=1 and data_rdata=0xDEADBEEF stable throughout.
  - A second data read is not granted, and inst still is.
  - On the rready=1 cycle, the second read is granted.
- Write during held read: data slot HELD, data_we=4'b1111 store request -> granted immediately; held value unchanged.
- Async reset mid-read: assert resetn=0 mid-cycle after a grant -> inst_rvalid/data_rvalid drop to 0 asynchronously; no rvalid after release. First conflict after release grants data.

Source files
------------

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the fetch
// read port and the data port, with a one-entry response hold slot per port.
module dram_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        inst_rready,
    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    input  logic        data_rready,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_INFLIGHT = 2'd1,
        SLOT_HELD     = 2'd2
    } slot_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_t;

    slot_t       r_instSlot;
    slot_t       r_dataSlot;
    logic [31:0] r_instHold;
    logic [31:0] r_dataHold;
    port_t       r_last;

    logic w_instFree;
    logic w_dataFree;
    logic w_dataRead;
    logic w_instElig;
    logic w_dataElig;
    logic w_instWins;

    assign inst_rvalid = (r_instSlot != SLOT_EMPTY);
    assign data_rvalid = (r_dataSlot != SLOT_EMPTY);

    assign w_instFree = inst_rvalid & inst_rready;
    assign w_dataFree = data_rvalid & data_rready;
    assign w_dataRead = (data_we == 4'b0000);

    // A freeing slot can accept a new read in the same cycle, giving back-to-back reads.
    assign w_instElig = inst_req & ((r_instSlot == SLOT_EMPTY) | w_instFree);
    assign w_dataElig = data_req & (~w_dataRead | (r_dataSlot == SLOT_EMPTY) | w_dataFree);

    assign w_instWins = w_instElig & (~w_dataElig | (r_last == PORT_DATA));
    assign inst_gnt   = w_instWins;
    assign data_gnt   = w_dataElig & ~w_instWins;
    assign ram_en     = inst_gnt | data_gnt;

    always_comb begin
        ram_addr  = 32'd0;
        ram_wdata = 32'd0;
        ram_we    = 4'b0000;
        if (inst_gnt) begin
            ram_addr = inst_addr;
        end else if (data_gnt) begin
            ram_addr  = data_addr;
            ram_wdata = data_wdata;
            ram_we    = data_we;
        end
    end

    always_comb begin
        inst_rdata = 32'd0;
        data_rdata = 32'd0;
        case (r_instSlot)
            SLOT_INFLIGHT: inst_rdata = ram_rdata;
            SLOT_HELD:     inst_rdata = r_instHold;
            default:       inst_rdata = 32'd0;
        endcase
        case (r_dataSlot)
            SLOT_INFLIGHT: data_rdata = ram_rdata;
            SLOT_HELD:     data_rdata = r_dataHold;
            default:       data_rdata = 32'd0;
        endcase
    end

    // RAM data is only on ram_rdata for one cycle, so a stalled consumer forces a capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_instSlot <= SLOT_EMPTY;
            r_dataSlot <= SLOT_EMPTY;
            r_instHold <= 32'd0;
            r_dataHold <= 32'd0;
            r_last     <= PORT_INST;
        end else begin
            if (inst_gnt) begin
                r_last <= PORT_INST;
            end else if (data_gnt) begin
                r_last <= PORT_DATA;
            end

            if (inst_gnt) begin
                r_instSlot <= SLOT_INFLIGHT;
            end else if ((r_instSlot == SLOT_INFLIGHT) && !inst_rready) begin
                r_instHold <= ram_rdata;
                r_instSlot <= SLOT_HELD;
            end else if (w_instFree) begin
                r_instSlot <= SLOT_EMPTY;
            end

            if (data_gnt && w_dataRead) begin
                r_dataSlot <= SLOT_INFLIGHT;
            end else if ((r_dataSlot == SLOT_INFLIGHT) && !data_rready) begin
                r_dataHold <= ram_rdata;
                r_dataSlot <= SLOT_HELD;
            end else if (w_dataFree) begin
                r_dataSlot <= SLOT_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: directed stimulus pushes expected read data,
// a negedge monitor pops and compares whenever a port hands over a response.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        inst_rready;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_rready;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] instExp [$];
    logic [31:0] dataExp [$];
    logic [31:0] mem [logic [31:0]];

    dram_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .inst_rready (inst_rready),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .data_rready (data_rready),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // Byte-enabled synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            logic [31:0] key;
            logic [31:0] word;
            key  = {ram_addr[31:2], 2'b00};
            word = mem.exists(key) ? mem[key] : 32'd0;
            if (ram_we != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) word[b*8 +: 8] = ram_wdata[b*8 +: 8];
                end
                mem[key] = word;
            end else begin
                ram_rdata <= word;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic iReady,
                                 input logic dReq, input logic [3:0] dWe, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata, input logic dReady);
        inst_req    = iReq;
        inst_addr   = iAddr;
        inst_rready = iReady;
        data_req    = dReq;
        data_we     = dWe;
        data_addr   = dAddr;
        data_wdata  = dWdata;
        data_rready = dReady;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every handed-over response must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (inst_rvalid && inst_rready) begin
                if (instExp.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL inst_unexpected: got rdata 0x%08h, expected no response", inst_rdata);
                end else begin
                    checkOutput("inst_rdata", inst_rdata, instExp.pop_front());
                end
            end
            if (data_rvalid && data_rready) begin
                if (dataExp.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL data_unexpected: got rdata 0x%08h, expected no response", data_rdata);
                end else begin
                    checkOutput("data_rdata", data_rdata, dataExp.pop_front());
                end
            end
        end
    end

    initial begin
        int iIdx;
        int dIdx;

        mem[32'h1C00_0000] = 32'h0280_0413;
        mem[32'h0000_0104] = 32'h1122_3344;
        mem[32'h0000_0200] = 32'hDEAD_BEEF;
        mem[32'h0000_0204] = 32'h5566_7788;
        mem[32'h0000_0208] = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            mem[32'h300 + 32'(k * 4)] = 32'hA000_0000 + 32'(k);
            mem[32'h400 + 32'(k * 4)] = 32'hB000_0000 + 32'(k);
        end

        resetn = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        #2;
        checkOutput("reset_inst_rvalid", 32'(inst_rvalid), 32'd0);
        checkOutput("reset_data_rvalid", 32'(data_rvalid), 32'd0);
        checkOutput("reset_inst_rdata", inst_rdata, 32'd0);
        checkOutput("reset_data_rdata", data_rdata, 32'd0);
        nextCycle;
        resetn = 1'b1;

        // Contested reads straight out of reset: data, inst, data, inst.
        iIdx = 0;
        dIdx = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(iIdx * 4), 1'b1,
                          1'b1, 4'b0000, 32'h400 + 32'(dIdx * 4), 32'd0, 1'b1);
            @(negedge clk);
            checkOutput("rr_data_gnt", 32'(data_gnt), 32'(i % 2 == 0));
            checkOutput("rr_inst_gnt", 32'(inst_gnt), 32'(i % 2 == 1));
            checkOutput("rr_ram_en", 32'(ram_en), 32'd1);
            if (i % 2 == 0) begin
                dataExp.push_back(32'hB000_0000 + 32'(dIdx));
                dIdx++;
            end else begin
                instExp.push_back(32'hA000_0000 + 32'(iIdx));
                iIdx++;
            end
            nextCycle;
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        nextCycle;

        // Single fetch.
        applyStimulus(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("fetch_inst_gnt", 32'(inst_gnt), 32'd1);
        checkOutput("fetch_ram_we", 32'(ram_we), 32'd0);
        checkOutput("fetch_ram_addr", ram_addr, 32'h1C00_0000);
        instExp.push_back(32'h0280_0413);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("fetch_inst_rvalid", 32'(inst_rvalid), 32'd1);
        nextCycle;

        // Byte store, then read back the merged word.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0100, 32'h104, 32'h00AB_0000, 1'b1);
        @(negedge clk);
        checkOutput("store_data_gnt", 32'(data_gnt), 32'd1);
        checkOutput("store_ram_we", 32'(ram_we), 32'h4);
        checkOutput("store_ram_wdata", ram_wdata, 32'h00AB_0000);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h104, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("store_no_rvalid", 32'(data_rvalid), 32'd0);
        checkOutput("reload_data_gnt", 32'(data_gnt), 32'd1);
        dataExp.push_back(32'h11AB_3344);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        nextCycle;

        // Back-pressure: held data read blocks a second data read but not fetches.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h200, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("bp_first_gnt", 32'(data_gnt), 32'd1);
        dataExp.push_back(32'hDEAD_BEEF);
        nextCycle;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1C00_0000, 1'b1, 1'b1, 4'b0000, 32'h204, 32'd0, 1'b0);
            @(negedge clk);
            checkOutput("bp_data_blocked", 32'(data_gnt), 32'd0);
            checkOutput("bp_inst_gnt", 32'(inst_gnt), 32'd1);
            checkOutput("bp_data_rvalid", 32'(data_rvalid), 32'd1);
            checkOutput("bp_data_rdata", data_rdata, 32'hDEAD_BEEF);
            instExp.push_back(32'h0280_0413);
            nextCycle;
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h204, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("bp_b2b_gnt", 32'(data_gnt), 32'd1);
        dataExp.push_back(32'h5566_7788);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        nextCycle;

        // Full-word store while a data read is held.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h208, 32'd0, 1'b0);
        @(negedge clk);
        dataExp.push_back(32'h0BAD_F00D);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b1111, 32'h20C, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        checkOutput("wh_data_gnt", 32'(data_gnt), 32'd1);
        checkOutput("wh_ram_we", 32'(ram_we), 32'hF);
        checkOutput("wh_held_rdata", data_rdata, 32'h0BAD_F00D);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("wh_held_after", data_rdata, 32'h0BAD_F00D);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 4'b0000, 32'h20C, 32'd0, 1'b1);
        @(negedge clk);
        dataExp.push_back(32'hCAFE_F00D);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        nextCycle;

        // Asynchronous reset with both ports holding outstanding reads.
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 4'b0000, 32'h200, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("ar_data_gnt", 32'(data_gnt), 32'd1);
        nextCycle;
        applyStimulus(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("ar_inst_gnt", 32'(inst_gnt), 32'd1);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
        checkOutput("ar_pre_inst_rvalid", 32'(inst_rvalid), 32'd1);
        checkOutput("ar_pre_data_rvalid", 32'(data_rvalid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("ar_inst_rvalid", 32'(inst_rvalid), 32'd0);
        checkOutput("ar_data_rvalid", 32'(data_rvalid), 32'd0);
        checkOutput("ar_inst_rdata", inst_rdata, 32'd0);
        checkOutput("ar_data_rdata", data_rdata, 32'd0);
        nextCycle;
        nextCycle;
        resetn = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("ar_post_inst_rvalid", 32'(inst_rvalid), 32'd0);
        checkOutput("ar_post_data_rvalid", 32'(data_rvalid), 32'd0);
        nextCycle;
        applyStimulus(1'b1, 32'h1C00_0000, 1'b1, 1'b1, 4'b0000, 32'h200, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("ar_conflict_data_gnt", 32'(data_gnt), 32'd1);
        checkOutput("ar_conflict_inst_gnt", 32'(inst_gnt), 32'd0);
        dataExp.push_back(32'hDEAD_BEEF);
        nextCycle;
        applyStimulus(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("ar_second_inst_gnt", 32'(inst_gnt), 32'd1);
        instExp.push_back(32'h0280_0413);
        nextCycle;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        nextCycle;
        nextCycle;

        checkOutput("inst_queue_drained", 32'(instExp.size()), 32'd0);
        checkOutput("data_queue_drained", 32'(dataExp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
